tpu_host_if: RTL and testbench
==============================

# tpu_host_if

Host-facing front end of the TPU. It accepts 32-bit host instructions over a valid/ready handshake, decodes the opcode, and runs a state machine that steers the following host data words either into the weight loader or into the unified buffer (UB). It also launches the matrix-multiply unit (MMU) and holds off new instructions until the MMU reports completion. It sits between the host port pins of `tpu` and the weight FIFO, the UB write port and the MMU control.

## Interface
- `N`, 4: systolic array dimension; one load is exactly N*N data words. Must be a power of two.
- `DW`, 8: host data word width.
- `AW`, 12: UB address width.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `host_instruction_valid` input 1: instruction present.
- `host_instruction` input 32: `[31:29]` opcode (`tpu_instruction_e`), `[28:0]` immediate.
- `host_instruction_ready` output 1: block can accept an instruction this cycle.
- `host_write_data` input DW: host data word.
- `host_wdata_valid` input 1: data word present. There is no backpressure on this input.
- `host_write_address` input AW: UB address for the data word; ignored for weights.
- `weight_wr_en` output 1: one-cycle weight write strobe.
- `weight_wr_data` output DW: weight value.
- `weight_wr_row`, `weight_wr_col` output $clog2(N) each: target PE coordinates.
- `ub_wr_en` output 1: one-cycle UB write strobe.
- `ub_wr_addr` output AW: UB write address.
- `ub_wr_data` output DW: UB write data.
- `mmu_start` output 1: one-cycle start pulse to the MMU.
- `mmu_done` input 1: level or pulse from the MMU indicating the pass is finished.
- `mmu_busy` output 1: high while in state RUN.
- `protocol_err` output 1: sticky protocol-violation flag.

## Operation
- Opcodes: 0 NOP, 1 READ_HOST_MEMORY, 2 READ_WEIGHTS, 3 MATRIX_MULTIPLY. Opcodes 4–7 are illegal.
- States: IDLE, LOAD_W, LOAD_UB, RUN.
- `host_instruction_ready` is high only in IDLE and is a pure decode of the registered state.
- An instruction is accepted when valid and ready are both high. Transitions on acceptance:
  - READ_WEIGHTS → LOAD_W.
  - READ_HOST_MEMORY → LOAD_UB.
  - MATRIX_MULTIPLY → RUN, with `mmu_start` pulsed.
  - NOP → stay in IDLE; if imm[0]=1, clear `protocol_err`.
  - Illegal opcode → stay in IDLE and set `protocol_err`.
- The word counter `wcnt` (0..N*N-1) is cleared on entry to LOAD_W and LOAD_UB.
- LOAD_W, on each `host_wdata_valid`:
  - `weight_wr_data` = data.
  - `weight_wr_row` = wcnt / N and `weight_wr_col` = wcnt % N, i.e. row-major order.
  - `wcnt` increments. After word N*N-1 the state returns to IDLE.
- LOAD_UB, on each `host_wdata_valid`:
  - `ub_wr_addr` = `host_write_address`, `ub_wr_data` = data.
  - `wcnt` increments. After word N*N-1 the state returns to IDLE.
  - The immediate is ignored.
- RUN: the state moves to IDLE in the cycle after `mmu_done` is sampled high. `mmu_done` is ignored during the cycle in which `mmu_start` is high.
- Data in the wrong state: `host_wdata_valid` while in IDLE or RUN, or in the same cycle as an accepted instruction, is dropped, is not counted, and sets `protocol_err`.
- Reset:
  - Every output is 0: strobes, data, addresses, row/col, `mmu_start`, `mmu_busy`, `protocol_err`.
  - `host_instruction_ready` is 1 (state IDLE), and `wcnt` is 0.
  - Reset asserted mid-load or mid-RUN abandons the operation. No further strobes are issued and `mmu_start` is not re-issued.

## Timing
- Instruction accepted at edge t: the new state is visible after t, so ready drops in cycle t+1. `mmu_start` is high for exactly cycle t+1.
- Write strobes are registered. Data sampled at edge t produces `weight_wr_en`/`ub_wr_en` with data, address, row and col during cycle t+1, for exactly one cycle.
- Back-to-back data (valid every cycle) is supported at full rate, one strobe per cycle.
- The last word of a load is sampled at edge t: ready is high from cycle t+1, so the next instruction can be accepted at edge t+1.
- `mmu_done` sampled at edge t in RUN: `mmu_busy` falls and ready rises in cycle t+1.
- `protocol_err` is set in the cycle after the offending edge and stays high until reset or a NOP with imm[0]=1.

## Test plan
- Weight load: READ_WEIGHTS, then 16 words 1,1,1,1,2,2,2,2,3,3,3,3,4,4,4,4 with idle gaps → 16 `weight_wr_en` pulses. Word 5 (value 2) lands at row 1, col 1; word 15 (value 4) at row 3, col 3. Ready returns after the 16th word; `protocol_err`=0.
- UB load: READ_HOST_MEMORY, then values 1..16 at addresses 0..15, back-to-back → 16 consecutive `ub_wr_en` cycles with addr k and data k+1. Ready is held low throughout the burst.
- Matmul: MATRIX_MULTIPLY → one `mmu_start` pulse and `mmu_busy`=1. Hold `mmu_done` low for 12 cycles, then pulse it → busy falls and ready rises one cycle later. An instruction offered while busy is not accepted.
- Illegal opcode 7 → accepted, no state change, `protocol_err`=1. A following NOP with imm=1 → `protocol_err`=0.
- Stray data: `host_wdata_valid` in IDLE, and in the same cycle as an accepted READ_WEIGHTS → no strobe in either case, the load still needs 16 further words, and `protocol_err`=1.
- Reset after the 7th weight word → all outputs 0 and ready=1. A new READ_WEIGHTS maps its first word to row 0, col 0.

Source files
------------

// File: rtl/tpu_host_if.sv
// Host front end of the TPU: instruction decode, load steering into the
// weight loader or unified buffer, and MMU launch/completion tracking.
module tpu_host_if #(
    parameter int N  = 4,
    parameter int DW = 8,
    parameter int AW = 12
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 host_instruction_valid,
    input  logic [31:0]          host_instruction,
    output logic                 host_instruction_ready,
    input  logic [DW-1:0]        host_write_data,
    input  logic                 host_wdata_valid,
    input  logic [AW-1:0]        host_write_address,
    output logic                 weight_wr_en,
    output logic [DW-1:0]        weight_wr_data,
    output logic [$clog2(N)-1:0] weight_wr_row,
    output logic [$clog2(N)-1:0] weight_wr_col,
    output logic                 ub_wr_en,
    output logic [AW-1:0]        ub_wr_addr,
    output logic [DW-1:0]        ub_wr_data,
    output logic                 mmu_start,
    input  logic                 mmu_done,
    output logic                 mmu_busy,
    output logic                 protocol_err
);

    localparam int RW = $clog2(N);
    localparam int CW = 2 * RW;

    typedef enum logic [2:0] {
        OP_NOP                = 3'd0,
        OP_READ_HOST_MEMORY   = 3'd1,
        OP_READ_WEIGHTS       = 3'd2,
        OP_MATRIX_MULTIPLY    = 3'd3
    } tpu_instruction_e;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD_W  = 2'd1,
        S_LOAD_UB = 2'd2,
        S_RUN     = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   wcnt_q, wcnt_d;
    logic            wen_q, wen_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [RW-1:0]   row_q, row_d;
    logic [RW-1:0]   col_q, col_d;
    logic            uen_q, uen_d;
    logic [AW-1:0]   uaddr_q, uaddr_d;
    logic [DW-1:0]   udata_q, udata_d;
    logic            start_q, start_d;
    logic            perr_q, perr_d;

    logic            accept;
    logic            last_word;
    logic [2:0]      opcode;
    logic            unused_imm;

    assign opcode     = host_instruction[31:29];
    assign unused_imm = ^host_instruction[28:1];
    assign accept     = host_instruction_valid && (state_q == S_IDLE);
    assign last_word  = (wcnt_q == {CW{1'b1}});

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        wen_d   = 1'b0;
        wdata_d = wdata_q;
        row_d   = row_q;
        col_d   = col_q;
        uen_d   = 1'b0;
        uaddr_d = uaddr_q;
        udata_d = udata_q;
        start_d = 1'b0;
        perr_d  = perr_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (opcode)
                        OP_NOP: begin
                            if (host_instruction[0]) perr_d = 1'b0;
                        end
                        OP_READ_HOST_MEMORY: begin
                            state_d = S_LOAD_UB;
                            wcnt_d  = '0;
                        end
                        OP_READ_WEIGHTS: begin
                            state_d = S_LOAD_W;
                            wcnt_d  = '0;
                        end
                        OP_MATRIX_MULTIPLY: begin
                            state_d = S_RUN;
                            start_d = 1'b1;
                        end
                        default: perr_d = 1'b1;
                    endcase
                end
                // stray data outranks a same-cycle NOP clear
                if (host_wdata_valid) perr_d = 1'b1;
            end
            S_LOAD_W: begin
                if (host_wdata_valid) begin
                    wen_d   = 1'b1;
                    wdata_d = host_write_data;
                    row_d   = wcnt_q[CW-1:RW];
                    col_d   = wcnt_q[RW-1:0];
                    wcnt_d  = wcnt_q + CW'(1);
                    if (last_word) state_d = S_IDLE;
                end
            end
            S_LOAD_UB: begin
                if (host_wdata_valid) begin
                    uen_d   = 1'b1;
                    uaddr_d = host_write_address;
                    udata_d = host_write_data;
                    wcnt_d  = wcnt_q + CW'(1);
                    if (last_word) state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (host_wdata_valid) perr_d = 1'b1;
                // done is not trusted while the start pulse is still out
                if (mmu_done && !start_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            row_q   <= '0;
            col_q   <= '0;
            uen_q   <= 1'b0;
            uaddr_q <= '0;
            udata_q <= '0;
            start_q <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            row_q   <= row_d;
            col_q   <= col_d;
            uen_q   <= uen_d;
            uaddr_q <= uaddr_d;
            udata_q <= udata_d;
            start_q <= start_d;
            perr_q  <= perr_d;
        end
    end

    assign host_instruction_ready = (state_q == S_IDLE);
    assign mmu_busy               = (state_q == S_RUN);
    assign weight_wr_en           = wen_q;
    assign weight_wr_data         = wdata_q;
    assign weight_wr_row          = row_q;
    assign weight_wr_col          = col_q;
    assign ub_wr_en               = uen_q;
    assign ub_wr_addr             = uaddr_q;
    assign ub_wr_data             = udata_q;
    assign mmu_start              = start_q;
    assign protocol_err           = perr_q;

endmodule

// File: tb/tb_tpu_host_if.sv
// Directed bench for tpu_host_if: loads, matmul handshake, protocol errors
// and mid-load reset, checked with immediate assertions.
module tb_tpu_host_if;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          host_instruction_valid;
    logic [31:0]   host_instruction;
    logic          host_instruction_ready;
    logic [DW-1:0] host_write_data;
    logic          host_wdata_valid;
    logic [AW-1:0] host_write_address;
    logic          weight_wr_en;
    logic [DW-1:0] weight_wr_data;
    logic [1:0]    weight_wr_row;
    logic [1:0]    weight_wr_col;
    logic          ub_wr_en;
    logic [AW-1:0] ub_wr_addr;
    logic [DW-1:0] ub_wr_data;
    logic          mmu_start;
    logic          mmu_done;
    logic          mmu_busy;
    logic          protocol_err;

    int total = 0;
    int bad   = 0;

    tpu_host_if #(.N(N), .DW(DW), .AW(AW)) dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .host_instruction_valid (host_instruction_valid),
        .host_instruction       (host_instruction),
        .host_instruction_ready (host_instruction_ready),
        .host_write_data        (host_write_data),
        .host_wdata_valid       (host_wdata_valid),
        .host_write_address     (host_write_address),
        .weight_wr_en           (weight_wr_en),
        .weight_wr_data         (weight_wr_data),
        .weight_wr_row          (weight_wr_row),
        .weight_wr_col          (weight_wr_col),
        .ub_wr_en               (ub_wr_en),
        .ub_wr_addr             (ub_wr_addr),
        .ub_wr_data             (ub_wr_data),
        .mmu_start              (mmu_start),
        .mmu_done               (mmu_done),
        .mmu_busy               (mmu_busy),
        .protocol_err           (protocol_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [28:0] imm);
        host_instruction       = {op, imm};
        host_instruction_valid = 1'b1;
        tick();
        host_instruction_valid = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wen"},   weight_wr_en,   0);
        chk({tag, "_wdat"},  weight_wr_data, 0);
        chk({tag, "_row"},   weight_wr_row,  0);
        chk({tag, "_col"},   weight_wr_col,  0);
        chk({tag, "_uen"},   ub_wr_en,       0);
        chk({tag, "_uadr"},  ub_wr_addr,     0);
        chk({tag, "_udat"},  ub_wr_data,     0);
        chk({tag, "_start"}, mmu_start,      0);
        chk({tag, "_busy"},  mmu_busy,       0);
        chk({tag, "_perr"},  protocol_err,   0);
        chk({tag, "_rdy"},   host_instruction_ready, 1);
    endtask

    initial begin
        reset_n                = 1'b0;
        host_instruction_valid = 1'b0;
        host_instruction       = '0;
        host_write_data        = '0;
        host_wdata_valid       = 1'b0;
        host_write_address     = '0;
        mmu_done               = 1'b0;

        tick();
        chk_all_zero("reset");
        reset_n = 1'b1;
        tick();

        // weight load with idle gaps, row-major placement
        issue(3'd2, 29'd0);
        chk("w_rdy_low", host_instruction_ready, 0);
        for (int k = 0; k < 16; k++) begin
            host_write_data  = DW'(k / 4 + 1);
            host_wdata_valid = 1'b1;
            tick();
            host_wdata_valid = 1'b0;
            chk("w_en",   weight_wr_en,   1);
            chk("w_data", weight_wr_data, k / 4 + 1);
            chk("w_row",  weight_wr_row,  k / 4);
            chk("w_col",  weight_wr_col,  k % 4);
            chk("w_rdy",  host_instruction_ready, (k == 15) ? 1 : 0);
            tick();
            chk("w_gap",  weight_wr_en, 0);
        end
        chk("w_perr", protocol_err, 0);

        // UB load, back-to-back
        issue(3'd1, 29'h1abc);
        for (int k = 0; k < 16; k++) begin
            host_write_address = AW'(k);
            host_write_data    = DW'(k + 1);
            host_wdata_valid   = 1'b1;
            tick();
            chk("ub_en",   ub_wr_en,   1);
            chk("ub_addr", ub_wr_addr, k);
            chk("ub_data", ub_wr_data, k + 1);
            chk("ub_wen",  weight_wr_en, 0);
            chk("ub_rdy",  host_instruction_ready, (k == 15) ? 1 : 0);
        end
        host_wdata_valid = 1'b0;
        tick();
        chk("ub_end", ub_wr_en, 0);
        chk("ub_perr", protocol_err, 0);

        // matmul with a blocked instruction offered while busy
        issue(3'd3, 29'd0);
        chk("mm_start", mmu_start, 1);
        chk("mm_busy",  mmu_busy,  1);
        chk("mm_rdy",   host_instruction_ready, 0);
        host_instruction       = {3'd2, 29'd0};
        host_instruction_valid = 1'b1;
        for (int c = 0; c < 11; c++) begin
            tick();
            chk("mm_start_once", mmu_start, 0);
            chk("mm_busy_hold",  mmu_busy,  1);
            chk("mm_rdy_hold",   host_instruction_ready, 0);
        end
        host_instruction_valid = 1'b0;
        mmu_done = 1'b1;
        tick();
        mmu_done = 1'b0;
        chk("mm_done_busy", mmu_busy, 0);
        chk("mm_done_rdy",  host_instruction_ready, 1);
        tick();
        chk("mm_not_taken", host_instruction_ready, 1);

        // done held high during the start cycle must be ignored
        mmu_done = 1'b1;
        issue(3'd3, 29'd0);
        chk("mm2_start", mmu_start, 1);
        chk("mm2_busy",  mmu_busy,  1);
        tick();
        chk("mm2_busy_ign", mmu_busy, 1);
        tick();
        mmu_done = 1'b0;
        chk("mm2_busy_end", mmu_busy, 0);
        chk("mm2_rdy",      host_instruction_ready, 1);
        chk("mm2_perr",     protocol_err, 0);

        // illegal opcode then clearing NOP
        issue(3'd7, 29'd0);
        chk("ill_rdy",  host_instruction_ready, 1);
        chk("ill_perr", protocol_err, 1);
        issue(3'd0, 29'd0);
        chk("nop0_perr", protocol_err, 1);
        issue(3'd0, 29'd1);
        chk("nop1_perr", protocol_err, 0);

        // stray data in IDLE
        host_write_data  = 8'hee;
        host_wdata_valid = 1'b1;
        tick();
        host_wdata_valid = 1'b0;
        chk("stray_wen",  weight_wr_en, 0);
        chk("stray_uen",  ub_wr_en, 0);
        chk("stray_perr", protocol_err, 1);
        issue(3'd0, 29'd1);
        chk("stray_clr", protocol_err, 0);

        // stray data on the accepting edge of READ_WEIGHTS
        host_wdata_valid = 1'b1;
        issue(3'd2, 29'd0);
        chk("acc_wen",  weight_wr_en, 0);
        chk("acc_perr", protocol_err, 1);
        chk("acc_rdy",  host_instruction_ready, 0);
        for (int k = 0; k < 16; k++) begin
            host_write_data = DW'(8'h10 + k);
            tick();
            chk("s_en",  weight_wr_en, 1);
            chk("s_dat", weight_wr_data, 8'h10 + k);
            chk("s_row", weight_wr_row, k / 4);
            chk("s_col", weight_wr_col, k % 4);
            chk("s_rdy", host_instruction_ready, (k == 15) ? 1 : 0);
        end
        host_wdata_valid = 1'b0;
        tick();
        chk("s_end", weight_wr_en, 0);

        // reset after the 7th weight word
        issue(3'd2, 29'd0);
        host_wdata_valid = 1'b1;
        for (int k = 0; k < 7; k++) begin
            host_write_data = DW'(k + 1);
            tick();
        end
        host_wdata_valid = 1'b0;
        chk("r7_en",  weight_wr_en, 1);
        chk("r7_col", weight_wr_col, 2);
        #2;
        reset_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        tick();
        chk_all_zero("midrst_hold");
        reset_n = 1'b1;
        tick();
        chk("post_rdy", host_instruction_ready, 1);
        issue(3'd2, 29'd0);
        host_write_data  = 8'h55;
        host_wdata_valid = 1'b1;
        tick();
        host_wdata_valid = 1'b0;
        chk("post_en",  weight_wr_en, 1);
        chk("post_dat", weight_wr_data, 8'h55);
        chk("post_row", weight_wr_row, 0);
        chk("post_col", weight_wr_col, 0);
        chk("post_rdy_low", host_instruction_ready, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
